mem_access_unit: RTL and testbench

MEM-stage load/store unit between the pipeline's EX/MEM register and a variable-latency data memory. It converts byte, halfword and word loads and stores into word-aligned memory transactions with byte enables. It stalls the pipeline until the memory acknowledges, then presents the extended load data as `read_data`, the memory-side input of the write-back select mux.

---
 rtl/mem_access_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns byte/half/word accesses into word-aligned
// memory transactions with byte enables. Optional trap build: MISALIGN_TRAP_EN.
module mem_access_unit #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   output logic        stall,
   output logic [31:0] read_data,
   output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   localparam logic [7:0] LastWait = 8'(ACK_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [29:0] r_wordAddr;
   logic [1:0]  r_lane;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_we;
   logic [31:0] r_wdata;
   logic [7:0]  r_waitCnt;
   logic        r_busErr;
`ifdef MISALIGN_TRAP_EN
   logic        r_misalign;
`endif

   logic        w_start;
   logic        w_misaligned;
   logic        w_timeout;
   logic [1:0]  w_lane;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_loadData;

   assign w_start   = mem_read | mem_write;
   assign w_timeout = ~dm_ack & (r_waitCnt == LastWait);

   // Lane is fixed at request time; ignored low address bits collapse to 0.
   always_comb begin
      w_lane = 2'b00;
      case (size)
         2'b00:   w_lane = addr[1:0];
         2'b01:   w_lane = {addr[1], 1'b0};
         default: w_lane = 2'b00;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign w_misaligned = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
`else
   assign w_misaligned = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      stall  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               stall  = 1'b1;
               w_next = w_misaligned ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (dm_ack || w_timeout) begin
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_be    = 4'hF;
      w_wdata = r_wdata;
      case (r_size)
         2'b00: begin
            w_be    = 4'b0001 << r_lane;
            w_wdata = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << r_lane;
            w_wdata = {2{r_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'hF;
            w_wdata = r_wdata;
         end
      endcase
   end

   // Bus outputs are only meaningful while a request is outstanding.
   assign dm_req   = (r_state == S_REQ);
   assign dm_we    = dm_req & r_we;
   assign dm_addr  = dm_req ? {r_wordAddr, 2'b00} : 32'h0;
   assign dm_wdata = dm_req ? w_wdata : 32'h0;
   assign dm_be    = dm_req ? w_be : 4'h0;

   always_comb begin
      w_shifted  = dm_rdata >> {r_lane, 3'b000};
      w_loadData = w_shifted;
      case (r_size)
         2'b00:   w_loadData = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_loadData = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         default: w_loadData = w_shifted;
      endcase
   end

   assign bus_err = r_busErr;
`ifdef MISALIGN_TRAP_EN
   assign misalign = r_misalign;
`endif

   // Error pulses are set on the transition into DONE, so they live one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wordAddr <= 30'h0;
         r_lane     <= 2'b00;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= 32'h0;
         r_waitCnt  <= 8'h0;
         r_busErr   <= 1'b0;
         read_data  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
         r_misalign <= 1'b0;
`endif
      end else begin
         r_state  <= w_next;
         r_busErr <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         r_misalign <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_wordAddr <= addr[31:2];
                  r_lane     <= w_lane;
                  r_size     <= size;
                  r_unsigned <= ld_unsigned;
                  r_we       <= mem_write;
                  r_wdata    <= write_data;
                  r_waitCnt  <= 8'h0;
`ifdef MISALIGN_TRAP_EN
                  if (w_misaligned) begin
                     r_misalign <= 1'b1;
                     if (!mem_write) begin
                        read_data <= 32'h0;
                     end
                  end
`endif
               end
            end
            S_REQ: begin
               if (dm_ack) begin
                  if (!r_we) begin
                     read_data <= w_loadData;
                  end
               end else if (w_timeout) begin
                  r_busErr <= 1'b1;
                  if (!r_we) begin
                     read_data <= 32'h0;
                  end
               end else begin
                  r_waitCnt <= r_waitCnt + 8'h1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level timeline model sets
// per-cycle expectations which are compared against the DUT every cycle.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [1:0]  size;
   logic        ld_unsigned;
   logic        stall;
   logic [31:0] read_data;
   logic        bus_err;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic [31:0] dm_rdata;
   logic        dm_ack;
`ifdef MISALIGN_TRAP_EN
   logic        misalign;
`endif

   mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .write_data (write_data),
      .size       (size),
      .ld_unsigned(ld_unsigned),
      .stall      (stall),
      .read_data  (read_data),
      .bus_err    (bus_err),
`ifdef MISALIGN_TRAP_EN
      .misalign   (misalign),
`endif
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_be      (dm_be),
      .dm_rdata   (dm_rdata),
      .dm_ack     (dm_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        expStall, expReq, expWe, expErr, expMis;
   logic [31:0] expAddr, expWdata, expRead;
   logic [3:0]  expBe;
   logic        chkBus, chkWdata;

   // Observation counters used by the hand-computed literal checks.
   int          stallCnt = 0, reqCnt = 0, errCnt = 0, misCnt = 0;
   logic [31:0] seenAddr = 32'h0, seenWdata = 32'h0;
   logic [3:0]  seenBe = 4'h0;
   logic        seenWe = 1'b0;

   always @(negedge clk) begin
      if (stall) stallCnt++;
      if (bus_err) errCnt++;
`ifdef MISALIGN_TRAP_EN
      if (misalign) misCnt++;
`endif
      if (dm_req) begin
         reqCnt++;
         seenAddr  = dm_addr;
         seenWdata = dm_wdata;
         seenBe    = dm_be;
         seenWe    = dm_we;
      end
   end

   function automatic int widthOf(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic int laneOf(input logic [31:0] a, input logic [1:0] sz);
      int low = int'(a[1:0]);
      if (sz == 2'b00) return low;
      if (sz == 2'b01) return (low / 2) * 2;
      return 0;
   endfunction

   function automatic logic isMisaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
      return ((sz == 2'b01) && a[0]) || ((sz >= 2'b10) && (a[1:0] != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] expectBe(input logic [31:0] a, input logic [1:0] sz);
      int mask = ((1 << widthOf(sz)) - 1) << laneOf(a, sz);
      return mask[3:0];
   endfunction

   function automatic logic [31:0] expectWdata(input logic [31:0] wd, input logic [1:0] sz);
      if (sz == 2'b00) return 32'(wd[7:0]) * 32'h0101_0101;
      if (sz == 2'b01) return 32'(wd[15:0]) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] expectLoad(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input logic uns);
      int          bits = 8 * widthOf(sz);
      logic [63:0] v    = {32'h0, rd} >> (8 * laneOf(a, sz));
      logic [63:0] mask = (64'h1 << bits) - 64'h1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic compareAll();
      checkOutput("stall", 32'(stall), 32'(expStall));
      checkOutput("dm_req", 32'(dm_req), 32'(expReq));
      checkOutput("dm_be", 32'(dm_be), 32'(expBe));
      checkOutput("read_data", read_data, expRead);
      checkOutput("bus_err", 32'(bus_err), 32'(expErr));
`ifdef MISALIGN_TRAP_EN
      checkOutput("misalign", 32'(misalign), 32'(expMis));
`endif
      if (chkBus) begin
         checkOutput("dm_addr", dm_addr, expAddr);
         checkOutput("dm_we", 32'(dm_we), 32'(expWe));
      end
      if (chkWdata) checkOutput("dm_wdata", dm_wdata, expWdata);
   endtask

   task automatic setExpIdle();
      expStall = 1'b0; expReq = 1'b0; expWe = 1'b0; expErr = 1'b0; expMis = 1'b0;
      expAddr = 32'h0; expWdata = 32'h0; expBe = 4'h0;
      chkBus = 1'b0; chkWdata = 1'b0;
   endtask

   // Compare the current cycle at its falling edge, then move past the next rise.
   task automatic tick();
      @(negedge clk);
      compareAll();
      @(posedge clk);
      #1;
   endtask

   // One access from its IDLE cycle to the following IDLE; ackAt < 0 means no ack.
   task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input logic uns,
                                input logic [31:0] rd, input int ackAt);
      logic done;
      mem_write = wr; mem_read = ~wr; addr = a; write_data = wd;
      size = sz; ld_unsigned = uns; dm_ack = 1'b0;
      setExpIdle();
      expStall = 1'b1;
      tick();
      addr = a ^ 32'h0000_0F03; write_data = ~wd; size = ~sz; ld_unsigned = ~uns;
      if (isMisaligned(a, sz)) begin
         setExpIdle();
         expMis = 1'b1;
         if (!wr) expRead = 32'h0;
      end else begin
         done = 1'b0;
         for (int k = 0; k < TO && !done; k++) begin
            setExpIdle();
            expStall = 1'b1; expReq = 1'b1; chkBus = 1'b1;
            expWe = wr; expAddr = {a[31:2], 2'b00}; expBe = expectBe(a, sz);
            chkWdata = wr; expWdata = expectWdata(wd, sz);
            dm_ack   = (k == ackAt);
            dm_rdata = dm_ack ? rd : (32'hA5A5_5A5A ^ 32'(k));
            tick();
            if (k == ackAt) begin
               done = 1'b1;
               setExpIdle();
               if (!wr) expRead = expectLoad(rd, a, sz, uns);
            end else if (k + 1 == TO) begin
               done = 1'b1;
               setExpIdle();
               expErr = 1'b1;
               if (!wr) expRead = 32'h0;
            end
         end
      end
      dm_ack = 1'b0;
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      setExpIdle();
   endtask

   int s0, r0, e0, m0;

   initial begin
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; write_data = 32'h0;
      size = 2'b00; ld_unsigned = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
      @(posedge clk); #1;
      setExpIdle();
      chkBus = 1'b1; chkWdata = 1'b1; expRead = 32'h0;
      tick();
      reset = 1'b0;
      setExpIdle();
      tick();

      // Signed byte load from the top lane, ack in the third REQ cycle.
      s0 = stallCnt;
      applyStimulus(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 32'h80FF_1234, 2);
      checkOutput("byte_load_value", read_data, 32'hFFFF_FF80);
      checkOutput("byte_load_stall_cycles", 32'(stallCnt - s0), 32'd4);

      // Half store with an immediate ack.
      applyStimulus(1'b1, 32'h22, 32'hDEAD_BEEF, 2'b01, 1'b0, 32'h0, 0);
      checkOutput("half_store_be", 32'(seenBe), 32'h0000_000C);
      checkOutput("half_store_wdata", seenWdata, 32'hBEEF_BEEF);
      checkOutput("half_store_addr", seenAddr, 32'h20);
      checkOutput("half_store_we", 32'(seenWe), 32'd1);
      checkOutput("store_keeps_read_data", read_data, 32'hFFFF_FF80);

      // Unsigned half load followed at once by a word load.
      applyStimulus(1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 32'h9ABC_0000, 1);
      checkOutput("uhalf_load_value", read_data, 32'h0000_9ABC);
      applyStimulus(1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 0);
      checkOutput("b2b_word_load_value", read_data, 32'h1234_5678);

      // Timeout with no ack.
      r0 = reqCnt; e0 = errCnt;
      applyStimulus(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 32'h0, -1);
      checkOutput("timeout_req_cycles", 32'(reqCnt - r0), 32'd4);
      checkOutput("timeout_err_pulses", 32'(errCnt - e0), 32'd1);
      checkOutput("timeout_read_data", read_data, 32'h0);

      // Ack in the last allowed cycle wins over the timeout.
      e0 = errCnt;
      applyStimulus(1'b0, 32'h1, 32'h0, 2'b00, 1'b1, 32'h0000_C300, TO - 1);
      checkOutput("late_ack_value", read_data, 32'h0000_00C3);
      checkOutput("late_ack_no_err", 32'(errCnt - e0), 32'd0);

      // Signed half, size 11 word store, byte store, timed-out store.
      applyStimulus(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 32'h0000_8001, 1);
      checkOutput("shalf_load_value", read_data, 32'hFFFF_8001);
      applyStimulus(1'b1, 32'h8, 32'h1122_3344, 2'b11, 1'b0, 32'h0, 1);
      checkOutput("size3_store_be", 32'(seenBe), 32'h0000_000F);
      applyStimulus(1'b1, 32'h5, 32'h0000_00AB, 2'b00, 1'b0, 32'h0, 2);
      checkOutput("byte_store_wdata", seenWdata, 32'hABAB_ABAB);
      applyStimulus(1'b1, 32'h60, 32'h0, 2'b10, 1'b0, 32'h0, -1);

      // An ack with no request outstanding is ignored.
      dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      dm_ack = 1'b0;

      // Misaligned accesses.
      applyStimulus(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h5555_AAAA, 0);
      s0 = stallCnt; r0 = reqCnt; m0 = misCnt;
      applyStimulus(1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 0);
`ifdef MISALIGN_TRAP_EN
      checkOutput("misalign_no_req", 32'(reqCnt - r0), 32'd0);
      checkOutput("misalign_pulses", 32'(misCnt - m0), 32'd1);
      checkOutput("misalign_stall_cycles", 32'(stallCnt - s0), 32'd1);
      checkOutput("misalign_read_data", read_data, 32'h0);
`else
      checkOutput("unaligned_word_addr", seenAddr, 32'h100);
      checkOutput("unaligned_word_be", 32'(seenBe), 32'h0000_000F);
      checkOutput("unaligned_word_value", read_data, 32'hCAFE_F00D);
      checkOutput("unaligned_word_req_cycles", 32'(reqCnt - r0), 32'd1);
      checkOutput("unaligned_marker", 32'(misCnt), 32'(m0));
`endif
      applyStimulus(1'b0, 32'h23, 32'h0, 2'b01, 1'b0, 32'h7FFF_0000, 0);

      // Reset while a request is outstanding.
      mem_read = 1'b1; addr = 32'h200; size = 2'b10; ld_unsigned = 1'b0; dm_ack = 1'b0;
      setExpIdle();
      expStall = 1'b1;
      tick();
      setExpIdle();
      expStall = 1'b1; expReq = 1'b1; chkBus = 1'b1; expAddr = 32'h200; expBe = 4'hF;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; mem_read = 1'b0;
      setExpIdle();
      chkBus = 1'b1; chkWdata = 1'b1; expRead = 32'h0;
      tick();
      setExpIdle();
      checkOutput("reset_read_data", read_data, 32'h0);

      // Unit works normally after the mid-request reset.
      applyStimulus(1'b0, 32'h2, 32'h0, 2'b00, 1'b0, 32'h0042_0000, 0);
      checkOutput("post_reset_load", read_data, 32'h0000_0042);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
